down_timer: RTL and testbench
=============================

DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 Parameter WIDTH, default 4, count and load width in bits.
REQ-002 Parameter PRE_W, default 8, prescaler width in bits.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 abort  input  1  return to IDLE and clear count; highest priority.
REQ-006 stop  input  1  pause a running countdown.
REQ-007 start  input  1  begin or resume countdown.
REQ-008 load  input  1  capture load_value.
REQ-009 load_value  input  WIDTH  countdown start and reload value.
REQ-010 periodic  input  1  1 = auto-reload mode, 0 = one-shot; sampled on each terminal tick.
REQ-011 prescale  input  PRE_W  tick every prescale+1 clk cycles while running.
REQ-012 count  output  WIDTH  current remaining count, registered.
REQ-013 busy  output  1  high in RUN state only.
REQ-014 done  output  1  single-cycle terminal-count pulse, registered.

Function
REQ-015 FSM states SHALL be IDLE, RUN and PAUSE.
REQ-016 Control priority SHALL be abort > stop > start > load when asserted in the same cycle.
REQ-017 abort, any state: next state IDLE, count 0, prescaler cleared, reload register unchanged.
REQ-018 load in IDLE or PAUSE: count and reload register both take load_value on the next edge.
REQ-019 load in RUN: only the reload register updates; count and prescaler are unaffected.
REQ-020 start in IDLE or PAUSE with count != 0: next state RUN, prescaler cleared to 0.
REQ-021 start with count == 0: ignored; state unchanged.
REQ-022 start in RUN: ignored.
REQ-023 stop in RUN: next state PAUSE; count held; prescaler cleared.
REQ-024 stop in IDLE or PAUSE: ignored.
REQ-025 Tick: the prescaler SHALL count 0..prescale while in RUN; a tick occurs in the cycle the prescaler equals prescale, and it then wraps to 0.
REQ-026 prescale = 0: a tick occurs every cycle in RUN.
REQ-027 Tick with count > 1: count decrements by 1.
REQ-028 Tick with count == 1, periodic = 0: count becomes 0, state becomes IDLE, done high for the following cycle.
REQ-029 Tick with count == 1, periodic = 1, reload != 0: count takes the reload value, state stays RUN, done high for the following cycle.
REQ-030 Tick with count == 1, periodic = 1, reload == 0: behaves as REQ-028.
REQ-031 Tick coinciding with abort or stop: abort or stop wins; no decrement and no done pulse.
REQ-032 done SHALL never be high for two consecutive cycles unless the reload value is 1 and prescale is 0.
REQ-033 count SHALL never wrap below 0.

Reset
REQ-034 Reset SHALL force state IDLE, count 0, reload register 0, prescaler 0, busy 0 and done 0, asynchronously.
REQ-035 Reset asserted mid-countdown SHALL abandon the countdown with no done pulse; after release the block waits in IDLE for load and start.

Structure
REQ-036 A shared package down_timer_pkg SHALL hold the state enum type (IDLE, RUN, PAUSE).
REQ-037 The prescaler SHALL be a sub-module, tick_gen, with ports clk, reset, clear, en, prescale and tick.
REQ-038 All outputs SHALL be driven directly from registers.

Verification
REQ-039 Reset release, load_value = 5, load, start, prescale = 0, periodic = 0 -> count runs 5,4,3,2,1,0; done high one cycle with count 0; busy drops; IDLE.
REQ-040 load 3, periodic = 1, prescale = 2, start -> each count value holds 3 cycles; sequence 3,2,1,3,2,1; done once per period.
REQ-041 Running at count 4, stop -> count holds 4 in PAUSE for 10 cycles; start -> resumes at 4, with first decrement prescale+1 cycles later.
REQ-042 Same-cycle abort+start+load (load_value 7) while RUN at count 2 -> IDLE, count 0, no done pulse.
REQ-043 start with count 0 -> stays IDLE, busy 0; load 9 during RUN with periodic = 1 -> next reload is 9.
REQ-044 Reset asserted asynchronously mid-count at count 6 -> count 0 immediately, no done pulse; after release, load 2 and start -> normal countdown.

Source files
------------

// File: rtl/down_timer_pkg.sv
// Shared types for the down_timer block.
package down_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/down_timer_tick_gen.sv
// Prescaler: counts 0..prescale while enabled and flags a tick on the last step.
module tick_gen #(
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] cnt;

  // >= rather than == so a prescale lowered mid-run cannot strand the counter above it
  assign tick = en && (cnt >= prescale);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/down_timer.sv
// Prescaled down-counter with one-shot / auto-reload modes and pause/abort control.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic             stop,
  input  logic             start,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             periodic,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nx;
  logic [WIDTH-1:0] reload, reload_nx, count_nx;
  logic             done_nx, busy_nx;
  logic             tick, run_en, pre_clear;

  assign run_en    = (state == RUN);
  assign pre_clear = abort || stop || (state != RUN);

  tick_gen #(.PRE_W(PRE_W)) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .clear    (pre_clear),
    .en       (run_en),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    state_nx  = state;
    count_nx  = count;
    reload_nx = reload;
    done_nx   = 1'b0;

    if (abort) begin
      state_nx = IDLE;
      count_nx = '0;
    end else begin
      case (state)
        RUN: begin
          if (stop) begin
            state_nx = PAUSE;
          end else begin
            if (load) reload_nx = load_value;
            // terminal tick reloads from the value held before any same-cycle load
            if (tick) begin
              if (count > WIDTH'(1)) begin
                count_nx = count - WIDTH'(1);
              end else if (count == WIDTH'(1)) begin
                done_nx = 1'b1;
                if (periodic && (reload != '0)) begin
                  count_nx = reload;
                end else begin
                  count_nx = '0;
                  state_nx = IDLE;
                end
              end else begin
                state_nx = IDLE;
              end
            end
          end
        end
        default: begin
          if (start && (count != '0)) begin
            state_nx = RUN;
          end else if (load) begin
            count_nx  = load_value;
            reload_nx = load_value;
          end
        end
      endcase
    end

    busy_nx = (state_nx == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      reload <= reload_nx;
      busy   <= busy_nx;
      done   <= done_nx;
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// Bench for down_timer: directed scenarios plus random control traffic against a cycle model.
module tb_down_timer;

  localparam int WIDTH = 4;
  localparam int PRE_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             abort = 1'b0, stop = 1'b0, start = 1'b0, load = 1'b0, periodic = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic [PRE_W-1:0] prescale = '0;
  logic [WIDTH-1:0] count;
  logic             busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  down_timer #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .abort      (abort),
    .stop       (stop),
    .start      (start),
    .load       (load),
    .load_value (load_value),
    .periodic   (periodic),
    .prescale   (prescale),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a timer is idle, running or paused; while running it spends
  // prescale+1 cycles per count step, and the step out of 1 ends or restarts the run.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE} mode_t;
  mode_t m_mode   = M_IDLE;
  int    m_count  = 0;
  int    m_reload = 0;
  int    m_phase  = 0;
  int    old_reload;
  bit    m_done   = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = M_IDLE; m_count = 0; m_reload = 0; m_phase = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (abort) begin
        m_mode = M_IDLE; m_count = 0; m_phase = 0;
      end else if (m_mode == M_RUN) begin
        if (stop) begin
          m_mode = M_PAUSE; m_phase = 0;
        end else begin
          old_reload = m_reload;
          if (load) m_reload = int'(load_value);
          if (m_phase < int'(prescale)) begin
            m_phase++;
          end else begin
            m_phase = 0;
            if (m_count > 1) begin
              m_count--;
            end else begin
              m_done = 1;
              if (periodic && old_reload != 0) m_count = old_reload;
              else begin m_count = 0; m_mode = M_IDLE; end
            end
          end
        end
      end else if (start && m_count != 0) begin
        m_mode = M_RUN; m_phase = 0;
      end else if (load) begin
        m_count = int'(load_value); m_reload = int'(load_value);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      chk("model_count", int'(count), m_count);
      chk("model_busy", int'(busy), int'(m_mode == M_RUN));
      chk("model_done", int'(done), int'(m_done));
    end
  end

  task automatic edge_s();
    @(posedge clk);
    #2;
  endtask

  int exp39[5] = '{4, 3, 2, 1, 0};

  initial begin
    #2 reset = 1'b1;
    #1;
    chk("reset_count", int'(count), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // one-shot countdown from 5 at full rate
    @(negedge clk); load_value = 4'd5; load = 1; prescale = 0; periodic = 0;
    edge_s(); chk("d39_load", int'(count), 5);
    @(negedge clk); load = 0; start = 1;
    edge_s(); chk("d39_start_count", int'(count), 5); chk("d39_start_busy", int'(busy), 1);
    @(negedge clk); start = 0;
    for (int i = 0; i < 5; i++) begin
      edge_s();
      chk("d39_count", int'(count), exp39[i]);
      chk("d39_done", int'(done), (i == 4) ? 1 : 0);
      chk("d39_busy", int'(busy), (i == 4) ? 0 : 1);
    end
    edge_s(); chk("d39_done_drop", int'(done), 0);

    // auto-reload of 3 with prescale 2
    @(negedge clk); load_value = 4'd3; load = 1; periodic = 1; prescale = 8'd2;
    edge_s();
    @(negedge clk); load = 0; start = 1;
    for (int i = 0; i < 18; i++) begin
      if (i > 0) begin @(negedge clk); start = 0; end
      edge_s();
      chk("d40_count", int'(count), 3 - ((i / 3) % 3));
      chk("d40_done", int'(done), (i == 9) ? 1 : 0);
    end
    @(negedge clk); start = 0; abort = 1;
    edge_s(); chk("d40_abort", int'(count), 0);
    @(negedge clk); abort = 0;

    // pause at 4 and resume
    load_value = 4'd4; load = 1; periodic = 0; prescale = 8'd1;
    edge_s();
    @(negedge clk); load = 0; start = 1;
    edge_s(); chk("d41_run", int'(count), 4);
    @(negedge clk); start = 0; stop = 1;
    edge_s(); chk("d41_pause_busy", int'(busy), 0);
    @(negedge clk); stop = 0;
    for (int i = 0; i < 10; i++) begin
      edge_s(); chk("d41_hold", int'(count), 4);
    end
    @(negedge clk); start = 1;
    edge_s(); chk("d41_resume", int'(count), 4); chk("d41_resume_busy", int'(busy), 1);
    @(negedge clk); start = 0;
    edge_s(); chk("d41_first_wait", int'(count), 4);
    edge_s(); chk("d41_first_dec", int'(count), 3);
    @(negedge clk); abort = 1;
    edge_s();
    @(negedge clk); abort = 0;

    // abort beats start and load in the same cycle
    load_value = 4'd3; load = 1; prescale = 0;
    edge_s();
    @(negedge clk); load = 0; start = 1;
    edge_s();
    @(negedge clk); start = 0;
    edge_s(); chk("d42_at2", int'(count), 2);
    @(negedge clk); abort = 1; start = 1; load = 1; load_value = 4'd7;
    edge_s();
    chk("d42_count", int'(count), 0); chk("d42_busy", int'(busy), 0); chk("d42_done", int'(done), 0);
    @(negedge clk); abort = 0; start = 0; load = 0;
    edge_s(); chk("d42_done_after", int'(done), 0);

    // start ignored at zero; load during run changes the next reload
    @(negedge clk); start = 1;
    edge_s(); chk("d43_zero_busy", int'(busy), 0); chk("d43_zero_count", int'(count), 0);
    @(negedge clk); start = 0; load_value = 4'd2; load = 1; periodic = 1;
    edge_s();
    @(negedge clk); load = 0; start = 1;
    edge_s(); chk("d43_run", int'(count), 2);
    @(negedge clk); start = 0; load = 1; load_value = 4'd9;
    edge_s(); chk("d43_dec", int'(count), 1);
    @(negedge clk); load = 0;
    edge_s(); chk("d43_reload", int'(count), 9); chk("d43_done", int'(done), 1);
    @(negedge clk); abort = 1; periodic = 0;
    edge_s();
    @(negedge clk); abort = 0;

    // asynchronous reset mid-countdown
    load_value = 4'd8; load = 1;
    edge_s();
    @(negedge clk); load = 0; start = 1;
    edge_s();
    @(negedge clk); start = 0;
    edge_s(); edge_s(); chk("d44_at6", int'(count), 6);
    #1 reset = 1'b1;
    #1;
    chk("d44_async_count", int'(count), 0);
    chk("d44_async_busy", int'(busy), 0);
    chk("d44_async_done", int'(done), 0);
    @(negedge clk); reset = 1'b0;
    edge_s(); chk("d44_no_done", int'(done), 0); chk("d44_idle", int'(busy), 0);
    @(negedge clk); load_value = 4'd2; load = 1;
    edge_s();
    @(negedge clk); load = 0; start = 1;
    edge_s(); chk("d44_run2", int'(count), 2);
    @(negedge clk); start = 0;
    edge_s(); chk("d44_run1", int'(count), 1);
    edge_s(); chk("d44_run0", int'(count), 0); chk("d44_done", int'(done), 1);

    // random control traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset      = ($urandom_range(0, 499) == 0);
      abort      = ($urandom_range(0, 99) < 2);
      stop       = ($urandom_range(0, 99) < 5);
      start      = ($urandom_range(0, 99) < 15);
      load       = ($urandom_range(0, 99) < 10);
      load_value = WIDTH'($urandom);
      if ($urandom_range(0, 19) == 0) periodic = ~periodic;
      if (m_mode == M_IDLE && $urandom_range(0, 9) == 0) prescale = PRE_W'($urandom_range(0, 3));
    end
    @(negedge clk);
    reset = 0; abort = 0; stop = 0; start = 0; load = 0;
    edge_s();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
